// File: rtl/i2c_pkg.sv
// Shared I2C constants and the slave FSM state encoding.
// The numeric state values are visible on state_dbg.
package i2c_pkg;

  localparam int unsigned CLK_FREQ   = 100_000_000;
  localparam logic [6:0]  SLAVE_ADDR = 7'h55;
  localparam int unsigned DATA_WIDTH = 8;
  localparam logic        I2C_WRITE  = 1'b0;
  localparam logic        I2C_READ   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WDATA    = 3'd3,
    ST_WACK     = 3'd4,
    ST_RDATA    = 3'd5,
    ST_RACK     = 3'd6
  } i2c_slv_state_t;

  function automatic logic state_is_busy(input i2c_slv_state_t s);
    return !(s == ST_IDLE || s == ST_ADDR);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line, plus registered rise/fall strobes.
// The strobes and o_level appear STAGES+1 clk after the pin changes and are aligned with each other.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Reset to 1 so that an idle, pulled-up bus produces no edge when reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every flop here the old value of its
      // neighbour, which is what makes this a chain of flops and not a single wire.
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with a 7-bit address and byte-wide read/write data.
// SDA is driven open-drain through sda_oe, and it changes only on a synchronized SCL falling strobe.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = i2c_pkg::SLAVE_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scl,
  input  logic                          sda_i,
  output logic                          sda_oe,
  output logic [i2c_pkg::DATA_WIDTH-1:0] rx_data,
  output logic                          rx_valid,
  input  logic [i2c_pkg::DATA_WIDTH-1:0] tx_data,
  output logic                          tx_load,
  output logic                          busy,
  output logic [2:0]                    state_dbg
);

  import i2c_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_load;
  logic [DATA_WIDTH-1:0] w_byte;

  i2c_slv_state_t        r_state, w_state_nxt;
  logic [2:0]            r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_phase, w_phase_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_sda_oe, w_sda_oe_nxt;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_tx_load, w_tx_load_nxt;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (scl),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (sda_i),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_byte  = {r_shift[DATA_WIDTH-2:0], w_sda};

  // r_phase splits each ACK slot into two halves: the drive half and the release half.
  // In RACK it records that the master has acknowledged.
  always_comb begin
    // NOTE: every signal gets its default value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_phase_nxt    = r_phase;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_load_nxt  = 1'b0;
    w_load         = 1'b0;

    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = 3'd0;
      w_phase_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_phase_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == LAST_BIT) begin
              w_phase_nxt = 1'b0;
              w_rw_nxt    = w_byte[0];
              w_state_nxt = (w_byte[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK, ST_WACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_nxt = 1'b1;
              w_phase_nxt  = 1'b1;
            end else if (r_state == ST_ADDR_ACK && r_rw == I2C_READ) begin
              w_load = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_phase_nxt  = 1'b0;
              w_cnt_nxt    = 3'd0;
              w_state_nxt  = ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == LAST_BIT) begin
              w_rx_data_nxt  = w_byte;
              w_rx_valid_nxt = 1'b1;
              w_phase_nxt    = 1'b0;
              w_state_nxt    = ST_WACK;
            end
          end
        end
        ST_RDATA: begin
          if (w_scl_fall) begin
            if (r_cnt == LAST_BIT) begin
              w_sda_oe_nxt = 1'b0;
              w_phase_nxt  = 1'b0;
              w_cnt_nxt    = 3'd0;
              w_state_nxt  = ST_RACK;
            end else begin
              w_shift_nxt  = {r_shift[DATA_WIDTH-2:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[DATA_WIDTH-2];
              w_cnt_nxt    = r_cnt + 3'd1;
            end
          end
        end
        ST_RACK: begin
          if (w_scl_rise && !r_phase) begin
            if (w_sda) w_state_nxt = ST_IDLE;
            else       w_phase_nxt = 1'b1;
          end else if (w_scl_fall && r_phase) begin
            w_load = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // The first bit of the new byte goes onto SDA on the same falling strobe that loads it.
    if (w_load) begin
      w_shift_nxt   = tx_data;
      w_tx_load_nxt = 1'b1;
      w_sda_oe_nxt  = ~tx_data[DATA_WIDTH-1];
      w_cnt_nxt     = 3'd0;
      w_phase_nxt   = 1'b0;
      w_state_nxt   = ST_RDATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_shift    <= '0;
      r_phase    <= 1'b0;
      r_rw       <= I2C_WRITE;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_phase    <= w_phase_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_load  <= w_tx_load_nxt;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_load   = r_tx_load;
  assign busy      = state_is_busy(r_state);
  assign state_dbg = r_state;

endmodule
